// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS-subset core with one shared ALU and a single req/ready memory port.
// Optional build macro MIPS_MC_OVF_TRAP_EN: signed overflow on add/sub/addi halts the core instead of wrapping.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] bt_q, bt_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mdr_q, mdr_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_now;
  logic        accept;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext;
  logic [31:0] add_res, sub_res, addi_res;
  logic        add_ovf, sub_ovf, addi_ovf;
  logic        op_known;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  assign add_res  = a_q + b_q;
  assign sub_res  = a_q - b_q;
  assign addi_res = a_q + imm_q;

`ifdef MIPS_MC_OVF_TRAP_EN
  assign add_ovf  = (a_q[31] == b_q[31])   && (add_res[31]  != a_q[31]);
  assign sub_ovf  = (a_q[31] != b_q[31])   && (sub_res[31]  != a_q[31]);
  assign addi_ovf = (a_q[31] == imm_q[31]) && (addi_res[31] != a_q[31]);
`else
  assign add_ovf  = 1'b0;
  assign sub_ovf  = 1'b0;
  assign addi_ovf = 1'b0;
`endif

  assign op_known = (opcode == OP_RTYPE) || (opcode == OP_J)   || (opcode == OP_BEQ) ||
                    (opcode == OP_BNE)   || (opcode == OP_ADDI) || (opcode == OP_LW) ||
                    (opcode == OP_SW);

  // A transfer completes only while our own request is up; stray ready pulses are ignored.
  assign accept = mem_req_q & mem_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    bt_d        = bt_q;
    alu_out_d   = alu_out_q;
    mdr_d       = mdr_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_we       = 1'b0;
    rf_waddr    = (opcode == OP_RTYPE) ? rd : rt;
    rf_wdata    = (opcode == OP_LW) ? mdr_q : alu_out_q;
    retire_now  = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (accept) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        imm_d = imm_sext;
        bt_d  = pc_q + {imm_sext[29:0], 2'b00};
        if ((opcode == HALT_OPCODE) || !op_known) state_d = S_HALT;
        else                                       state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            state_d = S_WB;
            case (funct)
              FN_ADD: begin
                alu_out_d = add_res;
                if (add_ovf) state_d = S_HALT;
              end
              FN_SUB: begin
                alu_out_d = sub_res;
                if (sub_ovf) state_d = S_HALT;
              end
              FN_AND:  alu_out_d = a_q & b_q;
              FN_OR:   alu_out_d = a_q | b_q;
              FN_SLT:  alu_out_d = {31'd0, $signed(a_q) < $signed(b_q)};
              FN_SLL:  alu_out_d = b_q << shamt;
              FN_SRL:  alu_out_d = b_q >> shamt;
              default: state_d   = S_HALT;
            endcase
          end
          OP_ADDI: begin
            alu_out_d = addi_res;
            state_d   = addi_ovf ? S_HALT : S_WB;
          end
          OP_LW, OP_SW: begin
            alu_out_d = addi_res;
            state_d   = (addi_res[1:0] != 2'b00) ? S_HALT : S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            if ((a_q == b_q) == (opcode == OP_BEQ)) pc_d = bt_q;
            retire_now = 1'b1;
            state_d    = S_FETCH;
          end
          OP_J: begin
            pc_d       = {pc_q[31:28], ir_q[25:0], 2'b00};
            retire_now = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (accept) begin
          if (opcode == OP_SW) begin
            retire_now = 1'b1;
            state_d    = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we      = (rf_waddr != 5'd0);
        retire_now = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Bus outputs are registered from the next state so a request is already up on state entry.
    if (state_d == S_FETCH) begin
      mem_req_d  = 1'b1;
      mem_addr_d = pc_d;
    end else if (state_d == S_MEM) begin
      mem_req_d   = 1'b1;
      mem_we_d    = (opcode == OP_SW);
      mem_addr_d  = alu_out_d;
      mem_wdata_d = b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      bt_q        <= '0;
      alu_out_q   <= '0;
      mdr_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      bt_q        <= bt_d;
      alu_out_q   <= alu_out_d;
      mdr_q       <= mdr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Reset wins immediately, so an in-flight request or write never shows while rst is high.
  assign mem_req   = mem_req_q & ~rst;
  assign mem_we    = mem_we_q & ~rst;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign retire    = retire_now & ~rst;
  assign halted    = (state_q == S_HALT) & ~rst;
  assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed vector table plus hand sequences for the multicycle MIPS core.
module tb_mips_multicycle;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  int          latency = 0;
  int          wait_cnt;
  logic [31:0] init_mem [256];
  logic [31:0] wr_mem   [256];
  logic        wr_valid [256];

  int          mon_cyc, retire_cnt, acc_cnt, wr_cnt, unstable_cnt, req_after_halt;
  int          retire_time [16];
  logic [31:0] acc_addr [16];
  logic [31:0] wr_addr, wr_data, saved_addr, saved_wdata;
  logic        saved_we, prev_wait;

  typedef struct {
    logic [4:0][31:0] prog;
    logic [31:0]      dword;
    logic [4:0]       chk_reg;
    logic [31:0]      exp_val;
    int               exp_retire;
    int               exp_cycles;
  } vec_t;

  vec_t vecs [16];
  int   nvec = 0;

  mips_multicycle #(.RESET_PC(32'h100), .HALT_OPCODE(6'h3F)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .halted(halted), .pc_dbg(pc_dbg)
  );

  always #5 clk = ~clk;

  // Memory model: ready after 'latency' waiting cycles; stores overlay the preloaded image.
  assign mem_ready = mem_req && (wait_cnt >= latency);
  assign mem_rdata = wr_valid[mem_addr[9:2]] ? wr_mem[mem_addr[9:2]] : init_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ready) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      mon_cyc        <= 0;
      retire_cnt     <= 0;
      acc_cnt        <= 0;
      wr_cnt         <= 0;
      unstable_cnt   <= 0;
      req_after_halt <= 0;
      prev_wait      <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      for (int i = 0; i < 256; i++) wr_valid[i] <= 1'b0;
    end else begin
      mon_cyc <= mon_cyc + 1;
      if (retire) begin
        if (retire_cnt < 16) retire_time[retire_cnt] <= mon_cyc;
        retire_cnt <= retire_cnt + 1;
      end
      if (mem_req && mem_ready) begin
        if (acc_cnt < 16) acc_addr[acc_cnt] <= mem_addr;
        acc_cnt <= acc_cnt + 1;
        if (mem_we) begin
          wr_cnt                   <= wr_cnt + 1;
          wr_addr                  <= mem_addr;
          wr_data                  <= mem_wdata;
          wr_mem[mem_addr[9:2]]    <= mem_wdata;
          wr_valid[mem_addr[9:2]]  <= 1'b1;
        end
      end
      if (prev_wait && mem_req &&
          (mem_addr != saved_addr || mem_we != saved_we || mem_wdata != saved_wdata))
        unstable_cnt <= unstable_cnt + 1;
      prev_wait   <= mem_req && !mem_ready;
      saved_addr  <= mem_addr;
      saved_we    <= mem_we;
      saved_wdata <= mem_wdata;
      if (halted && mem_req) req_after_halt <= req_after_halt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic loadProg(input logic [31:0] w0, w1, w2, w3, w4, dword);
    for (int i = 0; i < 256; i++) init_mem[i] = (i >= 64) ? HALT_W : 32'h0;
    init_mem[64] = w0;
    init_mem[65] = w1;
    init_mem[66] = w2;
    init_mem[67] = w3;
    init_mem[68] = w4;
    init_mem[16] = dword;
  endtask

  task automatic addVec(input logic [31:0] w0, w1, w2, w3, w4, dword,
                        input logic [4:0] r, input logic [31:0] val, input int ret, input int cyc);
    vecs[nvec].prog       = {w4, w3, w2, w1, w0};
    vecs[nvec].dword      = dword;
    vecs[nvec].chk_reg    = r;
    vecs[nvec].exp_val    = val;
    vecs[nvec].exp_retire = ret;
    vecs[nvec].exp_cycles = cyc;
    nvec++;
  endtask

  // Two reset cycles, then count cycles until halted (bounded).
  task automatic applyStimulus(input int lat, output int cyc);
    latency = lat;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    while (!halted && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("halt reached", {31'd0, halted}, 32'd1);
  endtask

  int cyc;

  initial begin
    // Arithmetic/logic vectors, mem_ready tied high
    addVec(32'h20010005, HALT_W, HALT_W, HALT_W, HALT_W, 0, 5'd1, 32'd5, 1, 7);
    addVec(32'h20010005, 32'h2002FFFD, 32'h00221820, HALT_W, HALT_W, 0, 5'd3, 32'd2, 3, 15);
    addVec(32'h20010005, 32'h2002FFFD, 32'h0041202A, HALT_W, HALT_W, 0, 5'd4, 32'd1, 3, 15);
    addVec(32'h20010005, 32'h2002FFFD, 32'h00221822, HALT_W, HALT_W, 0, 5'd3, 32'd8, 3, 15);
    addVec(32'h20010005, 32'h2002FFFD, 32'h00221825, HALT_W, HALT_W, 0, 5'd3, 32'hFFFFFFFD, 3, 15);
    addVec(32'h20010005, 32'h2002FFFD, 32'h00221824, HALT_W, HALT_W, 0, 5'd3, 32'd5, 3, 15);
    addVec(32'h20010005, 32'h00011900, HALT_W, HALT_W, HALT_W, 0, 5'd3, 32'h50, 2, 11);
    addVec(32'h20010005, 32'h2002FFFD, 32'h00021902, HALT_W, HALT_W, 0, 5'd3, 32'h0FFFFFFF, 3, 15);
    addVec(32'h20000007, HALT_W, HALT_W, HALT_W, HALT_W, 0, 5'd0, 32'd0, 1, 7);
    addVec(32'hF8000000, HALT_W, HALT_W, HALT_W, HALT_W, 0, 5'd0, 32'd0, 0, 3);
    addVec(32'h0000003F, HALT_W, HALT_W, HALT_W, HALT_W, 0, 5'd0, 32'd0, 0, 4);
`ifdef MIPS_MC_OVF_TRAP_EN
    addVec(32'h8C010040, 32'h20020001, 32'h00221820, HALT_W, HALT_W, 32'h7FFFFFFF,
           5'd3, 32'd0, 2, 13);
`else
    addVec(32'h8C010040, 32'h20020001, 32'h00221820, HALT_W, HALT_W, 32'h7FFFFFFF,
           5'd3, 32'h80000000, 3, 16);
`endif

    // Reset behaviour
    loadProg(HALT_W, HALT_W, HALT_W, HALT_W, HALT_W, 0);
    latency = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst retire", {31'd0, retire}, 32'd0);
    checkOutput("rst halted", {31'd0, halted}, 32'd0);
    checkOutput("rst pc_dbg", pc_dbg, 32'h100);
    checkOutput("rst mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    checkOutput("release mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    checkOutput("first mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("first mem_addr", mem_addr, 32'h100);
    checkOutput("first halted", {31'd0, halted}, 32'd0);

    for (int v = 0; v < nvec; v++) begin
      loadProg(vecs[v].prog[0], vecs[v].prog[1], vecs[v].prog[2], vecs[v].prog[3],
               vecs[v].prog[4], vecs[v].dword);
      applyStimulus(0, cyc);
      checkOutput($sformatf("vec%0d cycles", v), 32'(cyc), 32'(vecs[v].exp_cycles));
      checkOutput($sformatf("vec%0d retires", v), 32'(retire_cnt), 32'(vecs[v].exp_retire));
      checkOutput($sformatf("vec%0d reg%0d", v, vecs[v].chk_reg),
                  dut.rf_q[vecs[v].chk_reg], vecs[v].exp_val);
    end

    // Store then load with three wait cycles per transfer
    loadProg(32'h20010005, 32'hAC010008, 32'h8C050008, HALT_W, HALT_W, 0);
    applyStimulus(3, cyc);
    checkOutput("slow cycles", 32'(cyc), 32'd34);
    checkOutput("slow retires", 32'(retire_cnt), 32'd3);
    checkOutput("slow write count", 32'(wr_cnt), 32'd1);
    checkOutput("slow write addr", wr_addr, 32'h8);
    checkOutput("slow write data", wr_data, 32'd5);
    checkOutput("slow lw $5", dut.rf_q[5], 32'd5);
    checkOutput("slow req stable", 32'(unstable_cnt), 32'd0);

    // Branches and jump: fetch trace and 3-cycle spacing
    for (int i = 0; i < 256; i++) init_mem[i] = (i >= 64) ? HALT_W : 32'h0;
    init_mem[64] = 32'h20010005;
    init_mem[65] = 32'h14200002;
    init_mem[66] = 32'h20020001;
    init_mem[67] = 32'h20020002;
    init_mem[68] = 32'h10200002;
    init_mem[69] = 32'h20030009;
    init_mem[70] = 32'h08000048;
    init_mem[71] = 32'h20020003;
    applyStimulus(0, cyc);
    checkOutput("br cycles", 32'(cyc), 32'd20);
    checkOutput("br retires", 32'(retire_cnt), 32'd5);
    checkOutput("br fetches", 32'(acc_cnt), 32'd6);
    checkOutput("br fetch0", acc_addr[0], 32'h100);
    checkOutput("br fetch1", acc_addr[1], 32'h104);
    checkOutput("br bne taken", acc_addr[2], 32'h110);
    checkOutput("br beq not taken", acc_addr[3], 32'h114);
    checkOutput("br fetch4", acc_addr[4], 32'h118);
    checkOutput("br jump", acc_addr[5], 32'h120);
    checkOutput("br bne cpi", 32'(retire_time[1] - retire_time[0]), 32'd3);
    checkOutput("br beq cpi", 32'(retire_time[2] - retire_time[1]), 32'd3);
    checkOutput("br addi cpi", 32'(retire_time[3] - retire_time[2]), 32'd4);
    checkOutput("br j cpi", 32'(retire_time[4] - retire_time[3]), 32'd3);
    checkOutput("br $2 skipped", dut.rf_q[2], 32'd0);
    checkOutput("br $3", dut.rf_q[3], 32'd9);

    // Misaligned load halts without a data access; no requests afterwards
    loadProg(32'h8C050006, HALT_W, HALT_W, HALT_W, HALT_W, 0);
    applyStimulus(0, cyc);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("misalign cycles", 32'(cyc), 32'd4);
    checkOutput("misalign accesses", 32'(acc_cnt), 32'd1);
    checkOutput("misalign retires", 32'(retire_cnt), 32'd0);
    checkOutput("halt no req", 32'(req_after_halt), 32'd0);
    checkOutput("halt still halted", {31'd0, halted}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
